// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst-capable memory responder.
// Accepts FIXED/INCR/WRAP write and read bursts of 32-bit beats into a register array.
// Write and read channels run independently; each has its own small FSM.
// Optional: define AXI_SLAVE_WLAST_CHECK_EN to flag WLAST/beat-count mismatches as SLVERR.
`timescale 1ns/1ps

module axi4_burst_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // Write address
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // Write data
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // Write response
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    // Read address
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // Read data
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    // Address of the following beat for the given burst type.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] mask;
        // Wrap boundary is 4*(len+1) bytes, so boundary-1 == 4*len+3.
        mask = (ADDR_WIDTH'(len) << 2) | ADDR_WIDTH'(3);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + ADDR_WIDTH'(4)) & mask);
            default:     next_addr = addr + ADDR_WIDTH'(4);
        endcase
    endfunction

    // Whole-burst error: unsupported size, reserved burst type, or illegal WRAP length.
    function automatic logic burst_bad(input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_bad = (size != 3'b010) || (burst == BURST_RSVD) ||
                    ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = addr[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------------------------------------------------------- write channel
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_bad_q, w_bad_d;
    logic                  w_err_q, w_err_d;

    logic                    w_beat_oob;
    logic                    w_last_beat;
    logic                    w_wlast_err;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_widx;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;

    // Write FSM next-state and memory write-port decode.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_burst_d   = w_burst_q;
        w_bad_d     = w_bad_q;
        w_err_d     = w_err_q;
        mem_we      = 1'b0;
        mem_widx    = word_idx(w_addr_q);
        mem_wdata   = WDATA;
        mem_wstrb   = WSTRB;
        w_beat_oob  = (w_addr_q >= MEM_BYTES);
        w_last_beat = (w_cnt_q == w_len_q);
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        w_wlast_err = (WLAST != w_last_beat);
`else
        // WLAST is ignored; the burst ends on the AWLEN count alone.
        w_wlast_err = WLAST & 1'b0;
`endif
        unique case (w_state_q)
            WIdle: begin
                if (AWVALID && awready_q) begin
                    w_id_d    = AWID;
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_burst_d = AWBURST;
                    w_cnt_d   = 8'd0;
                    w_bad_d   = burst_bad(AWSIZE, AWLEN, AWBURST);
                    w_err_d   = burst_bad(AWSIZE, AWLEN, AWBURST);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (WVALID && wready_q) begin
                    mem_we   = !w_bad_q && !w_beat_oob;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_err_d  = w_err_q | w_beat_oob | w_wlast_err;
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q | w_beat_oob | w_wlast_err) ? RESP_SLVERR
                                                                         : RESP_OKAY;
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= WIdle;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we && !ARESET) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (mem_wstrb[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read channel
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  r_bad_q, r_bad_d;

    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic                  r_fetch_err;
    logic [DATA_WIDTH-1:0] r_fetch_data;

    // Read FSM next-state; the next beat is fetched from the array one cycle ahead of
    // presentation, so a same-cycle write to that word is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_bad_d   = r_bad_q;

        if (r_state_q == RIdle) begin
            r_fetch_addr = ARADDR;
            r_fetch_err  = burst_bad(ARSIZE, ARLEN, ARBURST) || (ARADDR >= MEM_BYTES);
        end else begin
            r_fetch_addr = r_addr_q;
            r_fetch_err  = r_bad_q || (r_addr_q >= MEM_BYTES);
        end
        r_fetch_data = r_fetch_err ? '0 : mem_q[word_idx(r_fetch_addr)];

        unique case (r_state_q)
            RIdle: begin
                if (ARVALID && arready_q) begin
                    r_id_d    = ARID;
                    r_len_d   = ARLEN;
                    r_burst_d = ARBURST;
                    r_bad_d   = burst_bad(ARSIZE, ARLEN, ARBURST);
                    r_addr_d  = next_addr(ARADDR, ARLEN, ARBURST);
                    r_cnt_d   = 8'd1;
                    rdata_d   = r_fetch_data;
                    rresp_d   = r_fetch_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (ARLEN == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = RIdle;
                    end else begin
                        rdata_d  = r_fetch_data;
                        rresp_d  = r_fetch_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_d  = (r_cnt_q == r_len_q);
                        r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= RIdle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_bad_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_bad_q   <= r_bad_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = w_id_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
    assign RID     = r_id_q;

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Self-checking bench for axi4_burst_slave_mem: directed cases plus randomized bursts,
// all checked against a word-array model of the memory and the AXI response rules.
`timescale 1ns/1ps

module tb_axi4_burst_slave_mem;

    localparam int MEM_DEPTH = 64;
    localparam int MEM_BYTES = 4 * MEM_DEPTH;
    localparam int TMO       = 200;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4_burst_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] model_mem [MEM_DEPTH];
    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] got_r[$];
    logic [1:0]  got_rresp[$];
    int          r_seen = 0;
    int unsigned cycle = 0;
    int unsigned aw_cycle = 0;
    int unsigned ar_cycle = 0;
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // ---------------------------------------------------------------- reference model
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int k);
        int unsigned b, lower;
        case (burst)
            2'b00: return start;
            2'b10: begin
                b = 4 * (len + 1);
                lower = (start / b) * b;
                return lower + ((start - lower + 4 * k) % b);
            end
            default: return start + 4 * k;
        endcase
    endfunction

    function automatic bit burst_ok(input logic [2:0] size, input int len,
                                    input logic [1:0] burst);
        return (size == 3'b010) && (burst != 2'b11) &&
               (burst != 2'b10 || len == 1 || len == 3 || len == 7 || len == 15);
    endfunction

    task automatic push_read_exp(input logic [3:0] id, input logic [31:0] addr,
                                 input int len, input logic [2:0] size,
                                 input logic [1:0] burst, input int nbeats);
        rbeat_t e;
        logic [31:0] a;
        bit err;
        for (int k = 0; k < nbeats; k++) begin
            a = beat_addr(addr, len, burst, k);
            err = !burst_ok(size, len, burst) || (a >= MEM_BYTES);
            e.id = id;
            e.data = err ? 32'h0 : model_mem[a / 4];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (k == len);
            exp_r.push_back(e);
        end
    endtask

    // ---------------------------------------------------------------- master drivers
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int early_last, input int gap_pct);
        bit err;
        logic [31:0] a;
        bexp_t eb;
        int n;
        err = !burst_ok(size, len, burst);
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, len, burst, k);
            if (burst_ok(size, len, burst)) begin
                if (a >= MEM_BYTES) err = 1'b1;
                else for (int i = 0; i < 4; i++)
                    if (sbuf[k][i]) model_mem[a / 4][8*i +: 8] = wbuf[k][8*i +: 8];
            end
        end
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        if (early_last >= 0 && early_last != len) err = 1'b1;
`endif
        eb.id = id;
        eb.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(eb);

        @(posedge ACLK); #1;
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < TMO);
        check("aw_handshake", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int k = 0; k <= len; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                WVALID = 1'b0;
                @(posedge ACLK); #1;
            end
            WDATA = wbuf[k]; WSTRB = sbuf[k];
            WLAST = (k == len) || (k == early_last);
            WVALID = 1'b1;
            n = 0;
            do begin @(negedge ACLK); n++; end while (!WREADY && n < TMO);
            check("w_handshake", WREADY, 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (gap_pct > 0) repeat ($urandom_range(3)) begin @(posedge ACLK); #1; end
        BREADY = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!BVALID && n < TMO);
        check("b_handshake", BVALID, 1);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    // rr_mode: 0 = RREADY held high, 1 = toggled every cycle, 2 = random.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int rr_mode);
        int n, target;
        push_read_exp(id, addr, len, size, burst, len + 1);
        target = r_seen + len + 1;
        @(posedge ACLK); #1;
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < TMO);
        check("ar_handshake", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        n = 0;
        while (r_seen < target && n < 4 * (len + 1) + TMO) begin
            case (rr_mode)
                0: RREADY = 1'b1;
                1: RREADY = ~RREADY;
                default: RREADY = 1'($urandom_range(1));
            endcase
            @(posedge ACLK); #1;
            n++;
        end
        RREADY = 1'b0;
        check("r_beats_done", r_seen, target);
    endtask

    // ---------------------------------------------------------------- compare process
    logic        r_stall = 1'b0;
    logic [31:0] r_prev_data;
    logic [1:0]  r_prev_resp;
    logic        r_prev_last;

    always @(negedge ACLK) begin : monitor
        rbeat_t er;
        bexp_t  eb;
        cycle++;
        if (ARESET) begin
            r_stall = 1'b0;
        end else begin
            if (AWVALID && AWREADY) aw_cycle = cycle;
            if (ARVALID && ARREADY) ar_cycle = cycle;
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    eb = exp_b.pop_front();
                    check("bid", BID, eb.id);
                    check("bresp", BRESP, eb.resp);
                end
            end
            if (RVALID && r_stall) begin
                check("rdata_hold", RDATA, r_prev_data);
                check("rresp_hold", RRESP, r_prev_resp);
                check("rlast_hold", RLAST, r_prev_last);
            end
            if (RVALID && RREADY) begin
                r_seen++;
                got_r.push_back(RDATA);
                got_rresp.push_back(RRESP);
                if (exp_r.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    er = exp_r.pop_front();
                    check("rid", RID, er.id);
                    check("rdata", RDATA, er.data);
                    check("rresp", RRESP, er.resp);
                    check("rlast", RLAST, er.last);
                end
            end
            r_stall = RVALID && !RREADY;
            r_prev_data = RDATA;
            r_prev_resp = RRESP;
            r_prev_last = RLAST;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        int target, n, len, early, sel;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] addr;
        int wl[4];
        wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", AWREADY, 1);
        check("rst_arready", ARREADY, 1);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_bid", BID, 0);
        check("rst_rid", RID, 0);
        check("rst_rdata", RDATA, 0);
        ARESET = 1'b0;

        // Fill word n = n, then WRAP len=3 from 0x28
        for (int k = 0; k < 64; k++) begin wbuf[k] = 32'(k); sbuf[k] = 4'hF; end
        do_write(4'h1, 32'h0, 63, 3'b010, 2'b01, -1, 0);
        got_r.delete(); got_rresp.delete();
        do_read(4'h2, 32'h28, 3, 3'b010, 2'b10, 0);
        check("wrap3_count", got_r.size(), 4);
        if (got_r.size() == 4) begin
            check("wrap3_b0", got_r[0], 32'hA);
            check("wrap3_b1", got_r[1], 32'hB);
            check("wrap3_b2", got_r[2], 32'h8);
            check("wrap3_b3", got_r[3], 32'h9);
        end

        // INCR len=15 at 0, read back as WRAP len=15
        wbuf[0] = 32'h00abcdef; sbuf[0] = 4'hF;
        for (int k = 1; k < 16; k++) begin wbuf[k] = 32'h11111111 * k; sbuf[k] = 4'hF; end
        do_write(4'h3, 32'h0, 15, 3'b010, 2'b01, -1, 0);
        got_r.delete(); got_rresp.delete();
        do_read(4'h4, 32'h0, 15, 3'b010, 2'b10, 0);
        check("wrap15_count", got_r.size(), 16);
        if (got_r.size() == 16) begin
            check("wrap15_b0", got_r[0], 32'h00abcdef);
            check("wrap15_b15", got_r[15], 32'hFFFFFFFF);
        end

        // FIXED len=3 at 0x10 with partial strobe on the last beat
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(4'h5, 32'h10, 0, 3'b010, 2'b01, -1, 0);
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'(k + 1); sbuf[k] = 4'hF; end
        sbuf[3] = 4'b0011;
        do_write(4'h6, 32'h10, 3, 3'b010, 2'b00, -1, 0);
        got_r.delete(); got_rresp.delete();
        do_read(4'h7, 32'h10, 0, 3'b010, 2'b01, 0);
        if (got_r.size() == 1) check("fixed_word4", got_r[0], 32'h00000004);
        else check("fixed_count", got_r.size(), 1);

        // Burst crossing the end of memory
        wbuf[0] = 32'h5A5A5A5A; wbuf[1] = 32'h12345678; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(4'h8, 32'hFC, 1, 3'b010, 2'b01, -1, 0);
        got_r.delete(); got_rresp.delete();
        do_read(4'h9, 32'hFC, 0, 3'b010, 2'b01, 0);
        do_read(4'hA, 32'h100, 0, 3'b010, 2'b01, 0);
        if (got_r.size() == 2) begin
            check("oob_word63", got_r[0], 32'h5A5A5A5A);
            check("oob_rdata", got_r[1], 32'h0);
            check("oob_rresp", got_rresp[1], 2'b10);
        end else check("oob_count", got_r.size(), 2);

        // Concurrent AW and AR with RREADY toggling
        for (int k = 0; k < 8; k++) begin wbuf[k] = 32'hC0DE0000 + 32'(k); sbuf[k] = 4'hF; end
        got_r.delete(); got_rresp.delete();
        fork
            do_write(4'hB, 32'h80, 7, 3'b010, 2'b01, -1, 0);
            do_read(4'hC, 32'h40, 7, 3'b010, 2'b01, 1);
        join
        check("aw_ar_same_cycle", ar_cycle, aw_cycle);
        if (got_r.size() == 8) check("conc_b0", got_r[0], 32'h10);

        // Reset during beat 2 of a len=7 read
        push_read_exp(4'hD, 32'h0, 7, 3'b010, 2'b01, 2);
        target = r_seen + 2;
        @(posedge ACLK); #1;
        ARID = 4'hD; ARADDR = 32'h0; ARLEN = 8'd7; ARSIZE = 3'b010; ARBURST = 2'b01;
        ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < TMO);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        n = 0;
        while (r_seen < target && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("mid_rst_beats", r_seen, target);
        RREADY = 1'b0;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_arready", ARREADY, 1);
        check("mid_rst_rlast", RLAST, 0);
        do_read(4'hE, 32'h40, 3, 3'b010, 2'b01, 0);

        // WLAST asserted early on beat 2 of a len=3 write
        for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hBEEF0000 + 32'(k); sbuf[k] = 4'hF; end
        do_write(4'hF, 32'h60, 3, 3'b010, 2'b01, 1, 0);
        do_read(4'h1, 32'h60, 3, 3'b010, 2'b01, 0);

        // Randomized bursts with handshake gaps and back-pressure
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(9);
            if (sel < 2) burst = 2'b00;
            else if (sel < 6) burst = 2'b01;
            else if (sel < 9) burst = 2'b10;
            else burst = 2'b11;
            if (burst == 2'b10 && $urandom_range(5) != 0) len = wl[$urandom_range(3)];
            else len = $urandom_range(15);
            size = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'b010;
            if ($urandom_range(4) == 0) addr = 32'(MEM_BYTES) - 32'(4 * $urandom_range(4));
            else addr = 32'(4 * $urandom_range(MEM_DEPTH - 1));
            for (int k = 0; k <= len; k++) begin
                wbuf[k] = $urandom;
                sbuf[k] = 4'($urandom_range(15));
            end
            early = ($urandom_range(7) == 0) ? $urandom_range(len) : -1;
            do_write(4'($urandom), addr, len, size, burst, early, 30);
            do_read(4'($urandom), addr, len, size, burst, 2);
        end

        repeat (4) @(posedge ACLK);
        check("r_queue_empty", exp_r.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_burst_slave_mem.md
Name: axi4_burst_slave_mem

Overview:
AXI4 (full) memory-mapped responder: the slave end of the burst traffic that the S00_AXI master BFM generates. It accepts FIXED/INCR/WRAP write and read bursts of 32-bit beats and stores them in an internal register-array memory. It sits behind the block-design interconnect as the burst-capable target for sequential write/read-back checks.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address bus width.
ID_WIDTH, 4, AXI ID width; IDs are echoed on B and R.
MEM_DEPTH, 64, number of 32-bit words; byte range is 0 to 4*MEM_DEPTH-1.

Ports:
ACLK  in  1  clock.
ARESET  in  1  synchronous, active-high reset.
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address.
AWVALID in 1; AWREADY out 1  write address handshake.
WDATA/WSTRB/WLAST  in  32/4/1  write data.
WVALID in 1; WREADY out 1  write data handshake.
BID/BRESP  out  ID_WIDTH/2  write response.
BVALID out 1; BREADY in 1  write response handshake.
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address.
ARVALID in 1; ARREADY out 1  read address handshake.
RID/RDATA/RRESP/RLAST  out  ID_WIDTH/32/2/1  read data.
RVALID out 1; RREADY in 1  read data handshake.

Behaviour:
- Reset (ARESET=1 on an ACLK edge): both FSMs return to IDLE; AWREADY=ARREADY=1; WREADY=BVALID=RVALID=RLAST=0; BRESP=RRESP=0; BID=RID=0; RDATA=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no B or R response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On an AW handshake, latch id/addr/len/size/burst, clear the error flag, go to W_DATA with WREADY=1 on the next cycle.
  - W_DATA: each W handshake writes the bytes enabled by WSTRB to word addr[..:2], then advances addr. After beat len+1: WREADY=0, BVALID=1 on the next cycle.
  - W_RESP: hold BID/BRESP until BREADY, then go to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On an AR handshake, latch the request; RVALID=1 with beat 0 on the next cycle.
  - R_DATA: RDATA/RRESP/RLAST stay stable while RVALID && !RREADY. With RREADY held, the block delivers one beat per cycle. RLAST=1 on beat len only. After the final handshake, RVALID=0 and ARREADY=1 on the next cycle.
- Address advance per beat:
  - FIXED: the address is unchanged.
  - INCR: address + 4.
  - WRAP: wrap boundary = 4*(len+1); next = (addr & ~(boundary-1)) | ((addr+4) & (boundary-1)).
- Errors, all reported as SLVERR=2'b10:
  - SIZE != 3'b010, burst type 2'b11, or WRAP with len not in {1,3,7,15}: the whole burst gets SLVERR, nothing is written, RDATA=0.
  - Beat address >= 4*MEM_DEPTH: that beat's write is dropped, its read returns 0, and the response is SLVERR. BRESP is SLVERR if any beat erred.
- Otherwise the response is OKAY=2'b00; EXOKAY is never returned.
- Write and read channels are independent and run concurrently. A same-cycle write and read to one word returns the old data.
- A burst crossing the memory end does not wrap into the array.

Optional Feature:
Macro AXI_SLAVE_WLAST_CHECK_EN.
- Defined: a WLAST value that mismatches the beat index (asserted early, or missing on beat len) forces BRESP=SLVERR. The burst still completes on beat count; writes are still performed.
- Undefined: WLAST is ignored and the burst is terminated solely by the AWLEN count.

Test Plan:
- INCR write, len=15, addr 0x0, data 0x00abcdef,0x11111111..0xFFFFFFFF -> BRESP=0. WRAP read len=15 at 0x0 returns the same 16 words, RLAST only on beat 15, RRESP=0.
- WRAP read len=3 at 0x28 after an INCR fill of word n = n -> beats from 0x28,0x2C,0x20,0x24 = 0xA,0xB,0x8,0x9.
- FIXED write len=3 at 0x10 with data 1,2,3,4 and WSTRB=4'b0011 on the last beat, initial word 0xFFFFFFFF -> word 4 = 0x00000004 after beat 4 (byte lanes 3:2 come from beat 3 = 0x0000 via full strobes). BRESP=0.
- INCR write len=1 at 0xFC with MEM_DEPTH=64 -> BRESP=SLVERR, word 63 written, beat 2 dropped. INCR read at 0x100 -> RDATA=0, RRESP=2'b10.
- Concurrent AW and AR in one cycle, RREADY toggled 1/0 per cycle -> both accepted in the same cycle, RDATA held during stalls, B and R both complete correctly.
- ARESET pulsed during beat 2 of a len=7 read -> RVALID=0, ARREADY=1 the next cycle; a new read proceeds normally. With AXI_SLAVE_WLAST_CHECK_EN defined, WLAST on beat 2 of len=3 -> BRESP=SLVERR.
